stream_dispatcher: RTL and testbench
====================================

STREAM_DISPATCHER -- requirements
Module: StreamDispatcher

Interface
REQ-001 Parameter WIDTH, default 8, payload bit width.
REQ-002 Parameter DEPTH, default 2, entries per output queue; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 io_in_valid  input  1  upstream transfer offered.
REQ-006 io_in_ready  output  1  dispatcher can accept the offered transfer.
REQ-007 io_in_bits  input  WIDTH  payload.
REQ-008 io_in_dest  input  2  destination output index, 0..3.
REQ-009 io_out_N_valid  output  1  (N=0..3) queue N holds at least one entry.
REQ-010 io_out_N_ready  input  1  (N=0..3) downstream N accepts the head entry.
REQ-011 io_out_N_bits  output  WIDTH  (N=0..3) head entry of queue N.
REQ-012 io_fire  output  1  io_in_valid & io_in_ready (combinational).
REQ-013 io_count  output  8  accepted-transfer counter; present only with DISPATCH_STATS_EN.

Function
REQ-014 Four independent FIFO queues SHALL exist, one per output, each DEPTH entries, with a read pointer, a write pointer and an occupancy count of 0..DEPTH.
REQ-015 io_in_ready SHALL be 1 when queue[io_in_dest] occupancy < DEPTH, else 0, combinational on io_in_dest and state only, never on io_in_valid.
REQ-016 When io_fire=1, io_in_bits SHALL be written to queue[io_in_dest] at its write pointer, which advances by 1 modulo DEPTH; no other queue is affected.
REQ-017 io_out_N_valid SHALL be 1 exactly when queue N occupancy > 0; io_out_N_bits SHALL present the entry at the read pointer.
REQ-018 When io_out_N_valid & io_out_N_ready, queue N SHALL dequeue, with the read pointer advancing by 1 modulo DEPTH.
REQ-019 Latency: an entry accepted in cycle t SHALL appear on its output no earlier than cycle t+1; there is no combinational flow-through, even when the queue is empty.
REQ-020 Simultaneous enqueue and dequeue on the same queue SHALL leave occupancy unchanged; both pointers advance.
REQ-021 Full queue: io_in_ready SHALL be 0 for that destination even if a dequeue occurs in the same cycle; no overwrite, no drop.
REQ-022 Dequeue from one queue and enqueue to another in the same cycle SHALL both take effect.
REQ-023 Entries SHALL leave each queue in acceptance order; there is no ordering guarantee across queues.
REQ-024 Bits offered while io_in_ready=0 SHALL NOT be stored; upstream holds them until accepted.

Reset
REQ-025 While reset=0 at a clock edge, all pointers and occupancies SHALL clear to 0, io_count SHALL clear to 0, and storage SHALL clear to 0.
REQ-026 After reset: io_out_N_valid=0, io_out_N_bits=0, io_in_ready=1, io_fire=io_in_valid.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries, and transfers presented in that cycle SHALL NOT be recorded.

Configuration
REQ-028 Macro DISPATCH_STATS_EN, when defined, SHALL add io_count, incremented by 1 on each io_fire cycle and wrapping 255->0.
REQ-029 Without DISPATCH_STATS_EN, io_count and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Reset, then in_valid=1, dest=2, bits=0xA5, out_2_ready=0 -> fire=1 that cycle; next cycle out_2_valid=1, out_2_bits=0xA5, other outputs valid=0.
REQ-031 Hold out_1_ready=0, send 0x11, 0x22, 0x33 to dest 1 -> first two accepted, in_ready=0 for the third; release ready -> out_1 yields 0x11 then 0x22, and 0x33 is accepted once space frees.
REQ-032 Queue 0 full, out_0_ready=1, in_valid=1, dest=0 -> in_ready=0 that cycle; next cycle in_ready=1.
REQ-033 Queue 3 full and dest=3 stalled; switch dest to 0 -> accepted immediately, and queue 3 contents are undisturbed.
REQ-034 With DISPATCH_STATS_EN, 257 accepted transfers -> io_count=1; assert reset mid-stream -> all valids=0 and io_count=0 next cycle.

Source files
------------

// File: rtl/stream_dispatcher.sv
// stream_dispatcher: routes one input stream into four DEPTH-entry FIFOs selected by io_in_dest (clk, active-low sync reset, io_in_* handshake, io_out_0..3_* outputs, io_fire, io_count only with DISPATCH_STATS_EN)
module stream_dispatcher #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  input  logic [1:0]       io_in_dest,
  output logic             io_out_0_valid,
  input  logic             io_out_0_ready,
  output logic [WIDTH-1:0] io_out_0_bits,
  output logic             io_out_1_valid,
  input  logic             io_out_1_ready,
  output logic [WIDTH-1:0] io_out_1_bits,
  output logic             io_out_2_valid,
  input  logic             io_out_2_ready,
  output logic [WIDTH-1:0] io_out_2_bits,
  output logic             io_out_3_valid,
  input  logic             io_out_3_ready,
  output logic [WIDTH-1:0] io_out_3_bits,
  output logic             io_fire
`ifdef DISPATCH_STATS_EN
  ,
  output logic [7:0]       io_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [4][DEPTH];
  logic [AW-1:0] rp [4];
  logic [AW-1:0] wp [4];
  logic [CW-1:0] cnt [4];
  logic [3:0] rdy, vld, deq, enq;
  assign rdy = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};
  assign io_in_ready = cnt[io_in_dest] < CW'(DEPTH);
  assign io_fire = io_in_valid & io_in_ready;
  always_comb begin
    for (int q = 0; q < 4; q++) begin
      vld[q] = cnt[q] != '0;
      deq[q] = vld[q] & rdy[q];
      enq[q] = io_fire & (io_in_dest == 2'(q));
    end
  end
  assign io_out_0_valid = vld[0];
  assign io_out_1_valid = vld[1];
  assign io_out_2_valid = vld[2];
  assign io_out_3_valid = vld[3];
  assign io_out_0_bits = mem[0][rp[0]];
  assign io_out_1_bits = mem[1][rp[1]];
  assign io_out_2_bits = mem[2][rp[2]];
  assign io_out_3_bits = mem[3][rp[3]];
  always_ff @(posedge clk) begin
    for (int q = 0; q < 4; q++) begin
      if (!reset) begin
        rp[q] <= '0;
        wp[q] <= '0;
        cnt[q] <= '0;
        for (int i = 0; i < DEPTH; i++) mem[q][i] <= '0;
      end else begin
        if (enq[q]) begin
          mem[q][wp[q]] <= io_in_bits;
          wp[q] <= wp[q] + AW'(1);
        end
        if (deq[q]) rp[q] <= rp[q] + AW'(1);
        cnt[q] <= cnt[q] + CW'(enq[q]) - CW'(deq[q]);
      end
    end
  end
`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) io_count <= '0;
    else if (io_fire) io_count <= io_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_stream_dispatcher.sv
// tb_stream_dispatcher: scoreboard bench for stream_dispatcher with directed and random steps
module tb_stream_dispatcher;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_bits = '0;
  logic [1:0] in_dest = '0;
  logic [3:0] ordy = '0;
  logic in_ready, fire;
  logic [3:0] ov;
  logic [7:0] ob [4];
`ifdef DISPATCH_STATS_EN
  logic [7:0] count;
`endif
  int n_assert = 0;
  int n_fail = 0;
  int acc = 0;
  logic [7:0] exp_q [4][$];

  always #5 clk = ~clk;

  stream_dispatcher dut (
    .clk(clk), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready), .io_in_bits(in_bits), .io_in_dest(in_dest),
    .io_out_0_valid(ov[0]), .io_out_0_ready(ordy[0]), .io_out_0_bits(ob[0]),
    .io_out_1_valid(ov[1]), .io_out_1_ready(ordy[1]), .io_out_1_bits(ob[1]),
    .io_out_2_valid(ov[2]), .io_out_2_ready(ordy[2]), .io_out_2_bits(ob[2]),
    .io_out_3_valid(ov[3]), .io_out_3_ready(ordy[3]), .io_out_3_bits(ob[3]),
    .io_fire(fire)
`ifdef DISPATCH_STATS_EN
    , .io_count(count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle, check against the model, update the model, cross the edge.
  task automatic tick();
    logic m_ready;
    #1;
    if (reset) begin
      m_ready = exp_q[in_dest].size() < 2;
      chk("in_ready", in_ready, m_ready);
      chk("fire", fire, in_valid && m_ready);
      for (int q = 0; q < 4; q++) begin
        chk($sformatf("valid%0d", q), ov[q], exp_q[q].size() != 0);
        if (exp_q[q].size() != 0) begin
          chk($sformatf("bits%0d", q), ob[q], exp_q[q][0]);
          if (ordy[q]) void'(exp_q[q].pop_front());
        end
      end
      if (in_valid && m_ready) begin
        exp_q[in_dest].push_back(in_bits);
        acc++;
      end
    end else begin
      for (int q = 0; q < 4; q++) exp_q[q].delete();
      acc = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic [7:0] b);
    in_valid = 1'b1;
    in_dest = d;
    in_bits = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    tick();
    tick();
    #1;
    chk("rst_valids", ov, 4'b0000);
    for (int q = 0; q < 4; q++) chk($sformatf("rst_bits%0d", q), ob[q], 8'h00);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_fire0", fire, 1'b0);
    in_valid = 1'b1;
    #1;
    chk("rst_fire1", fire, 1'b1);
`ifdef DISPATCH_STATS_EN
    chk("rst_count", count, 8'd0);
`endif
    in_valid = 1'b0;
    reset = 1'b1;
    // single transfer, no flow-through
    ordy = 4'b0000;
    in_valid = 1'b1; in_dest = 2'd2; in_bits = 8'hA5;
    #1;
    chk("a5_fire", fire, 1'b1);
    chk("a5_noflow", ov, 4'b0000);
    tick();
    in_valid = 1'b0;
    #1;
    chk("a5_valid", ov, 4'b0100);
    chk("a5_bits", ob[2], 8'hA5);
    ordy = 4'b0100;
    tick();
    ordy = 4'b0000;
    // back-pressure on queue 1
    send(2'd1, 8'h11);
    send(2'd1, 8'h22);
    in_valid = 1'b1; in_bits = 8'h33;
    #1;
    chk("q1_full_ready", in_ready, 1'b0);
    tick();
    ordy = 4'b0010;
    #1;
    chk("q1_full_deq_ready", in_ready, 1'b0);
    chk("q1_head11", ob[1], 8'h11);
    tick();
    chk("q1_ready_freed", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    chk("q1_drained", ov[1], 1'b0);
    ordy = 4'b0000;
    // full queue 0 with dequeue in the same cycle
    send(2'd0, 8'h01);
    send(2'd0, 8'h02);
    ordy = 4'b0001;
    in_valid = 1'b1; in_dest = 2'd0; in_bits = 8'h55;
    #1;
    chk("q0_full_ready", in_ready, 1'b0);
    tick();
    chk("q0_next_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    ordy = 4'b0000;
    // stalled queue 3, switch to queue 0
    send(2'd3, 8'h31);
    send(2'd3, 8'h32);
    in_valid = 1'b1; in_dest = 2'd3; in_bits = 8'h33;
    tick();
    in_dest = 2'd0; in_bits = 8'h40;
    #1;
    chk("switch_fire", fire, 1'b1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("q3_head", ob[3], 8'h31);
    chk("switch_valids", ov, 4'b1001);
    ordy = 4'b1111;
    repeat (3) tick();
    chk("all_drained", ov, 4'b0000);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom);
      in_dest = 2'($urandom);
      in_bits = 8'($urandom);
      ordy = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
    ordy = 4'b1111;
    repeat (3) tick();
    // counter wrap: reset, then 257 accepted transfers
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1;
      in_dest = 2'(i);
      in_bits = 8'(i * 7);
      tick();
    end
    in_valid = 1'b0;
    chk("accepted_257", acc, 257);
`ifdef DISPATCH_STATS_EN
    chk("count_wrap", count, 8'd1);
`endif
    // reset mid-stream discards everything, including the transfer presented then
    ordy = 4'b0000;
    send(2'd0, 8'hC0);
    send(2'd1, 8'hC1);
    send(2'd2, 8'hC2);
    reset = 1'b0;
    in_valid = 1'b1; in_dest = 2'd3; in_bits = 8'h77;
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_valids", ov, 4'b0000);
    chk("midrst_bits3", ob[3], 8'h00);
`ifdef DISPATCH_STATS_EN
    chk("midrst_count", count, 8'd0);
`endif
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
